// File: rtl/aib_rx_word_aligner.sv
// AIB receive word aligner.
// Builds two candidate words from the per-lane DDR halves: phase 0 is the
// natural pairing and phase 1 is slipped by half a cycle. An alignment marker
// is hunted on both, confirmed on the chosen phase, and then payload words
// are forwarded while a marker-gap watchdog keeps the lock honest.
module aib_rx_word_aligner #(
  parameter int                 NumIo      = 20,
  parameter logic [2*NumIo-1:0] Marker     = {NumIo{2'b01}},
  parameter int                 ConfirmCnt = 4,
  parameter int                 Timeout    = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 c_align_en,
  input  logic                 i_rx_data0 [NumIo],
  input  logic                 i_rx_data1 [NumIo],
  output logic [2*NumIo-1:0]   o_data,
  output logic                 o_valid,
  output logic                 o_locked,
  output logic                 o_phase,
  output logic [7:0]           o_relock_cnt
);

  localparam int         W        = 2 * NumIo;
  localparam logic [3:0] ConfLim  = 4'(ConfirmCnt);
  localparam logic [9:0] TmoLast  = 10'(Timeout - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Input capture: current halves of both lanes plus the previous falling half.
  logic [NumIo-1:0] cur0_q, cur1_q, prev1_q;

  // Candidate words for the two phases and the one selected by the FSM.
  logic [W-1:0] word0, word1, sel_word;

  // FSM and output state.
  state_e       state_q, state_d;
  logic         phase_q, phase_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [9:0]   tmo_q, tmo_d;
  logic [7:0]   relock_q, relock_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Register both DDR halves every cycle and keep one cycle of falling-half history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur0_q  <= '0;
      cur1_q  <= '0;
      prev1_q <= '0;
    end else begin
      for (int k = 0; k < NumIo; k++) begin
        cur0_q[k] <= i_rx_data0[k];
        cur1_q[k] <= i_rx_data1[k];
      end
      prev1_q <= cur1_q;
    end
  end

  // Interleave lane bits into the phase-0 and half-cycle-slipped phase-1 words.
  always_comb begin
    word0 = '0;
    word1 = '0;
    for (int k = 0; k < NumIo; k++) begin
      word0[2*k]   = cur0_q[k];
      word0[2*k+1] = cur1_q[k];
      word1[2*k]   = prev1_q[k];
      word1[2*k+1] = cur0_q[k];
    end
    sel_word = phase_q ? word1 : word0;
  end

  // Next-state logic: marker search, confirmation run, and locked forwarding with watchdog.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    relock_d = relock_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    if (!c_align_en) begin
      state_d = SEARCH;
      cnt_d   = '0;
      tmo_d   = '0;
      if (state_q == LOCKED) relock_d = sat_inc8(relock_q);
    end else begin
      case (state_q)
        SEARCH: begin
          // Phase 0 takes priority when both candidates show the marker.
          if (word0 == Marker) begin
            state_d = CONFIRM;
            phase_d = 1'b0;
            cnt_d   = 4'd1;
          end else if (word1 == Marker) begin
            state_d = CONFIRM;
            phase_d = 1'b1;
            cnt_d   = 4'd1;
          end
        end
        CONFIRM: begin
          if (sel_word == Marker) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= ConfLim) begin
              state_d = LOCKED;
              tmo_d   = '0;
            end
          end else begin
            state_d = SEARCH;
            cnt_d   = '0;
          end
        end
        LOCKED: begin
          if (sel_word == Marker) begin
            // A marker always refreshes the watchdog, even on its last cycle.
            tmo_d = '0;
          end else begin
            valid_d = 1'b1;
            data_d  = sel_word;
            if (tmo_q >= TmoLast) begin
              state_d  = SEARCH;
              tmo_d    = '0;
              cnt_d    = '0;
              relock_d = sat_inc8(relock_q);
            end else begin
              tmo_d = tmo_q + 10'd1;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= SEARCH;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      relock_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      relock_q <= relock_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_locked     = (state_q == LOCKED);
  assign o_phase      = phase_q;
  assign o_relock_cnt = relock_q;

endmodule

// File: tb/tb_aib_rx_word_aligner.sv
// Directed bench for the AIB receive word aligner.
module tb_aib_rx_word_aligner;
  localparam int NumIo = 20;
  localparam int W     = 2 * NumIo;
  localparam logic [W-1:0] MK = {NumIo{2'b01}};
  localparam logic [W-1:0] PA = 40'hA5A5A5A5A5;
  localparam logic [W-1:0] PB = 40'h123456789A;
  localparam logic [W-1:0] ZW = 40'h0;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic d0 [NumIo];
  logic d1 [NumIo];
  logic [W-1:0] o_data, o1_data;
  logic o_valid, o_locked, o_phase, o1_valid, o1_locked, o1_phase;
  logic [7:0] o_relock, o1_relock;
  logic [NumIo-1:0] odd_prev;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aib_rx_word_aligner #(.NumIo(NumIo), .Marker(MK), .ConfirmCnt(4), .Timeout(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .c_align_en(en),
    .i_rx_data0(d0), .i_rx_data1(d1),
    .o_data(o_data), .o_valid(o_valid), .o_locked(o_locked),
    .o_phase(o_phase), .o_relock_cnt(o_relock)
  );

  aib_rx_word_aligner #(.NumIo(NumIo), .Marker(MK), .ConfirmCnt(1), .Timeout(64)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .c_align_en(en),
    .i_rx_data0(d0), .i_rx_data1(d1),
    .o_data(o1_data), .o_valid(o1_valid), .o_locked(o1_locked),
    .o_phase(o1_phase), .o_relock_cnt(o1_relock)
  );

  // Drive one transmitted word; ph=1 splits it across two cycles (half-cycle slip).
  task automatic push(input logic [W-1:0] w, input logic ph);
    for (int k = 0; k < NumIo; k++) begin
      if (!ph) begin
        d0[k] = w[2*k];
        d1[k] = w[2*k+1];
      end else begin
        d1[k] = w[2*k];
        d0[k] = odd_prev[k];
      end
    end
    for (int k = 0; k < NumIo; k++) odd_prev[k] = w[2*k+1];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    odd_prev = '0;
    for (int k = 0; k < NumIo; k++) begin
      d0[k] = 1'b0;
      d1[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    odd_prev = '0;
    for (int k = 0; k < NumIo; k++) begin
      d0[k] = 1'b0;
      d1[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_data, o_valid, o_locked, o_phase, o_relock} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b l=%b p=%b r=%0d want all 0",
               o_data, o_valid, o_locked, o_phase, o_relock);
    end
    rst_n = 1'b1;
    push(ZW, 1'b0);
    checks++;
    if (o_locked !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got l=%b v=%b want 0 0", o_locked, o_valid);
    end
  endtask

  task automatic test_lock_phase0();
    do_reset();
    push(ZW, 1'b0);
    push(ZW, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(MK, 1'b0);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL p0_marker_valid[%0d]: got %b want 0", i, o_valid);
      end
    end
    push(PA, 1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_valid !== 1'b0 || o_phase !== 1'b0) begin
      errors++;
      $display("FAIL p0_lock: got l=%b v=%b p=%b want 1 0 0", o_locked, o_valid, o_phase);
    end
    push(PA, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_data !== PA) begin
      errors++;
      $display("FAIL p0_payload: got v=%b data=%h want 1 %h", o_valid, o_data, PA);
    end
    push(MK, 1'b0);
    push(PB, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_locked !== 1'b1 || o_data !== PA) begin
      errors++;
      $display("FAIL p0_marker_in_lock: got v=%b l=%b data=%h want 0 1 %h",
               o_valid, o_locked, o_data, PA);
    end
    push(PB, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_data !== PB) begin
      errors++;
      $display("FAIL p0_payload2: got v=%b data=%h want 1 %h", o_valid, o_data, PB);
    end
  endtask

  task automatic test_lock_phase1();
    do_reset();
    push(ZW, 1'b1);
    push(ZW, 1'b1);
    for (int i = 0; i < 4; i++) push(MK, 1'b1);
    push(PA, 1'b1);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL p1_early_lock: got l=%b want 0", o_locked);
    end
    push(PB, 1'b1);
    checks++;
    if (o_locked !== 1'b1 || o_phase !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL p1_lock: got l=%b p=%b v=%b want 1 1 0", o_locked, o_phase, o_valid);
    end
    push(PA, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== PA) begin
      errors++;
      $display("FAIL p1_payloadA: got v=%b data=%h want 1 %h", o_valid, o_data, PA);
    end
    push(ZW, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== PB) begin
      errors++;
      $display("FAIL p1_payloadB: got v=%b data=%h want 1 %h", o_valid, o_data, PB);
    end
  endtask

  task automatic test_confirm1();
    do_reset();
    push(ZW, 1'b0);
    push(ZW, 1'b0);
    push(MK, 1'b0);
    push(MK, 1'b0);
    checks++;
    if (o1_locked !== 1'b0) begin
      errors++;
      $display("FAIL c1_one_marker: got l=%b want 0", o1_locked);
    end
    push(PA, 1'b0);
    checks++;
    if (o1_locked !== 1'b1 || o_locked !== 1'b0) begin
      errors++;
      $display("FAIL c1_two_markers: got l1=%b l4=%b want 1 0", o1_locked, o_locked);
    end
    push(PA, 1'b0);
    checks++;
    if (o1_valid !== 1'b1 || o1_data !== PA) begin
      errors++;
      $display("FAIL c1_payload: got v=%b data=%h want 1 %h", o1_valid, o1_data, PA);
    end
  endtask

  task automatic test_confirm_abort();
    do_reset();
    push(ZW, 1'b0);
    push(ZW, 1'b0);
    push(MK, 1'b0);
    push(MK, 1'b0);
    push(ZW, 1'b0);
    push(MK, 1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL abort_after_corrupt: got l=%b want 0", o_locked);
    end
    push(MK, 1'b0);
    push(MK, 1'b0);
    push(MK, 1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL abort_count_restart: got l=%b want 0", o_locked);
    end
    push(PA, 1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_relock !== 8'd0) begin
      errors++;
      $display("FAIL abort_relock: got l=%b r=%0d want 1 0", o_locked, o_relock);
    end
    push(PA, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_data !== PA) begin
      errors++;
      $display("FAIL abort_payload: got v=%b data=%h want 1 %h", o_valid, o_data, PA);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push(ZW, 1'b0);
    push(ZW, 1'b0);
    for (int i = 0; i < 4; i++) push(MK, 1'b0);
    for (int i = 0; i < 64; i++) push(PA, 1'b0);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL tmo_before: got l=%b want 1", o_locked);
    end
    push(PA, 1'b0);
    checks++;
    if (o_locked !== 1'b0 || o_relock !== 8'd1) begin
      errors++;
      $display("FAIL tmo_exit: got l=%b r=%0d want 0 1", o_locked, o_relock);
    end
    push(PA, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_data !== PA) begin
      errors++;
      $display("FAIL tmo_search_hold: got v=%b data=%h want 0 %h", o_valid, o_data, PA);
    end
    do_reset();
    push(ZW, 1'b0);
    push(ZW, 1'b0);
    for (int i = 0; i < 4; i++) push(MK, 1'b0);
    for (int i = 0; i < 63; i++) push(PA, 1'b0);
    push(MK, 1'b0);
    for (int i = 0; i < 20; i++) push(PA, 1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_relock !== 8'd0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_marker63: got l=%b r=%0d v=%b want 1 0 1", o_locked, o_relock, o_valid);
    end
  endtask

  task automatic test_align_en();
    do_reset();
    push(ZW, 1'b0);
    push(ZW, 1'b0);
    for (int i = 0; i < 4; i++) push(MK, 1'b0);
    push(PB, 1'b0);
    push(PB, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_data !== PB || o_relock !== 8'd0) begin
      errors++;
      $display("FAIL en_pre: got v=%b data=%h r=%0d want 1 %h 0", o_valid, o_data, o_relock, PB);
    end
    en = 1'b0;
    push(PA, 1'b0);
    en = 1'b1;
    checks++;
    if (o_locked !== 1'b0 || o_valid !== 1'b0 || o_relock !== 8'd1 || o_data !== PB) begin
      errors++;
      $display("FAIL en_drop: got l=%b v=%b r=%0d data=%h want 0 0 1 %h",
               o_locked, o_valid, o_relock, o_data, PB);
    end
    for (int n = 2; n <= 256; n++) begin
      for (int i = 0; i < 4; i++) push(MK, 1'b0);
      push(PA, 1'b0);
      if (n == 256) begin
        checks++;
        if (o_locked !== 1'b1) begin
          errors++;
          $display("FAIL en_relock_256: got l=%b want 1", o_locked);
        end
      end
      en = 1'b0;
      push(PA, 1'b0);
      en = 1'b1;
      if (n == 255) begin
        checks++;
        if (o_relock !== 8'd255) begin
          errors++;
          $display("FAIL en_count_255: got %0d want 255", o_relock);
        end
      end
    end
    checks++;
    if (o_relock !== 8'd255) begin
      errors++;
      $display("FAIL en_saturate: got %0d want 255", o_relock);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(ZW, 1'b0);
    push(ZW, 1'b0);
    for (int i = 0; i < 4; i++) push(MK, 1'b0);
    push(PA, 1'b0);
    en = 1'b0;
    push(PA, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) push(MK, 1'b0);
    push(PA, 1'b0);
    push(PA, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_relock !== 8'd1) begin
      errors++;
      $display("FAIL rst_mid_pre: got v=%b r=%0d want 1 1", o_valid, o_relock);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_data, o_valid, o_locked, o_phase, o_relock} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got data=%h v=%b l=%b p=%b r=%0d want all 0",
               o_data, o_valid, o_locked, o_phase, o_relock);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push(MK, 1'b0);
    push(PA, 1'b0);
    push(PA, 1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_three_markers: got l=%b want 0", o_locked);
    end
    for (int i = 0; i < 4; i++) push(MK, 1'b0);
    push(PA, 1'b0);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_relock: got l=%b want 1", o_locked);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    odd_prev = '0;
    test_reset();
    test_lock_phase0();
    test_lock_phase1();
    test_confirm1();
    test_confirm_abort();
    test_timeout();
    test_align_en();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
